// File: rtl/conv55_window_gen_if.sv
// conv55_window_gen_if: pixel-in / window-out handshake bundle for the 5x5 window generator.
// Optional position outputs appear when CONV55_WIN_POS_EN is defined.
interface conv55_window_gen_if #(
  parameter int DATA_W = 6,
  parameter int XW     = 5,
  parameter int YW     = 5
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_W-1:0]     pix_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [25*DATA_W-1:0]  win_data;
  logic                  frame_done;
`ifdef CONV55_WIN_POS_EN
  logic [XW-1:0]         win_x;
  logic [YW-1:0]         win_y;
`endif
  modport slave (
    input  pix_valid, pix_data, win_ready,
`ifdef CONV55_WIN_POS_EN
    output win_x, win_y,
`endif
    output pix_ready, win_valid, win_data, frame_done
  );
  modport master (
    output pix_valid, pix_data, win_ready,
`ifdef CONV55_WIN_POS_EN
    input  win_x, win_y,
`endif
    input  pix_ready, win_valid, win_data, frame_done
  );
endinterface

// File: rtl/conv55_window_gen.sv
// conv55_window_gen: streaming 5x5 valid-region window generator (4 line buffers + 5x5 register window).
// Define CONV55_WIN_POS_EN to add registered output-map coordinates win_x/win_y.
module conv55_window_gen #(
  parameter int DATA_W = 6,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  conv55_window_gen_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int WW = 25 * DATA_W;

  logic [XW-1:0]     r_col;
  logic [YW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb [4][IMG_W];
  logic [WW-1:0]     r_win;
  logic [WW-1:0]     r_win_data;
  logic              r_win_valid;
  logic              r_frame_done;
  logic              r_last;
  logic [WW-1:0]     w_nxt;
  logic [DATA_W-1:0] w_col [5];
  logic              w_acc;
  logic              w_emit;
  logic              w_last;
  logic              w_col_end;
`ifdef CONV55_WIN_POS_EN
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  assign bus.win_x = r_x;
  assign bus.win_y = r_y;
`endif

  assign bus.pix_ready  = rst_n && (!r_win_valid || bus.win_ready);
  assign bus.win_valid  = r_win_valid;
  assign bus.win_data   = r_win_data;
  assign bus.frame_done = r_frame_done;

  assign w_acc     = bus.pix_valid && bus.pix_ready && !flush;
  assign w_emit    = w_acc && (r_row >= YW'(4)) && (r_col >= XW'(4));
  assign w_col_end = r_col == XW'(IMG_W - 1);
  assign w_last    = w_col_end && (r_row == YW'(IMG_H - 1));

  // New right column, oldest line at the top
  always_comb begin
    w_col[0] = r_lb[3][r_col];
    w_col[1] = r_lb[2][r_col];
    w_col[2] = r_lb[1][r_col];
    w_col[3] = r_lb[0][r_col];
    w_col[4] = bus.pix_data;
  end

  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < 5; c++) begin : g_col
      if (c < 4) begin : g_shift
        assign w_nxt[DATA_W*(5*r+c) +: DATA_W] = r_win[DATA_W*(5*r+c+1) +: DATA_W];
      end else begin : g_new
        assign w_nxt[DATA_W*(5*r+c) +: DATA_W] = w_col[r];
      end
    end
  end

  // Line buffers and the shift window carry no reset; stale contents never reach the output
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb[0][r_col] <= bus.pix_data;
      r_lb[1][r_col] <= r_lb[0][r_col];
      r_lb[2][r_col] <= r_lb[1][r_col];
      r_lb[3][r_col] <= r_lb[2][r_col];
      r_win          <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
      r_frame_done <= 1'b0;
      r_last       <= 1'b0;
`ifdef CONV55_WIN_POS_EN
      r_x          <= '0;
      r_y          <= '0;
`endif
    end else if (flush) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_win_valid && bus.win_ready && r_last;
      if (w_acc) begin
        r_col <= w_col_end ? '0 : r_col + XW'(1);
        r_row <= !w_col_end ? r_row : (r_row == YW'(IMG_H - 1)) ? '0 : r_row + YW'(1);
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_nxt;
        r_last      <= w_last;
`ifdef CONV55_WIN_POS_EN
        r_x         <= r_col - XW'(4);
        r_y         <= r_row - YW'(4);
`endif
      end else if (bus.win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end
endmodule
